bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter SPLIT_EN, default 1, meaning: 1 enables split handling, 0 makes ssplit ignored.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 breq1  input  1  master 1 bus request, level, held for the whole transaction.
REQ-005 breq2  input  1  master 2 bus request, level, held for the whole transaction.
REQ-006 bgrant1  output  1  master 1 owns bus (registered).
REQ-007 bgrant2  output  1  master 2 owns bus (registered).
REQ-008 msel  output  1  bus mux select, 0 = master 1, 1 = master 2 (registered).
REQ-009 msplit1  output  1  master 1 suspended by split.
REQ-010 msplit2  output  1  master 2 suspended by split.
REQ-011 ssplit  input  1  from slave; rising edge = split start, held high until slave ready, low = ready to resume.
REQ-012 split_grant  output  1  to slaves, one-cycle pulse: split transaction resumes.

Function
REQ-013 The arbiter SHALL implement states IDLE, M1, M2, RESUME, with bgrant1 = (M1 or RESUME with split owner 1) and bgrant2 likewise.
REQ-014 bgrant1 and bgrant2 SHALL never be high together.
REQ-015 IDLE SHALL last at least one cycle after every M1/M2 exit (one turnaround cycle).
REQ-016 In IDLE with a split pending and ssplit low, the arbiter SHALL go to RESUME, ahead of any new request.
REQ-017 Otherwise in IDLE, the arbiter SHALL serve eligible requests round-robin: if only one eligible master requests, grant it; if both request, grant the master not served last; the last-served pointer resets to master 2 (master 1 wins the first tie).
REQ-018 A master whose msplitN is high SHALL be ineligible, and its breq SHALL be don't-care while suspended.
REQ-019 Grant latency SHALL be one cycle: request sampled in IDLE at edge k, bgrantN high after edge k.
REQ-020 In M1/M2, breq of the owner sampled low SHALL move to IDLE; bgrantN deasserts after that same edge.
REQ-021 In M1/M2 with SPLIT_EN=1, ssplit rising edge sampled (ssplit=1, previous sample 0) SHALL set msplitN of the owner, drop its grant and move to IDLE on that edge.
REQ-022 Only one split SHALL be outstanding; an ssplit rising edge while a split is pending SHALL be ignored.
REQ-023 If ssplit falls while another master owns the bus, the resume SHALL wait until that master releases and the turnaround IDLE cycle occurs.
REQ-024 RESUME SHALL last exactly one cycle, with split_grant=1 and the split owner's bgrant=1, then go to M1/M2 of that owner, clearing its msplitN on the same edge.
REQ-025 msel SHALL update on the edge that asserts a grant and hold its value in IDLE.
REQ-026 A simultaneous breq drop and ssplit rising edge in M1/M2 SHALL be treated as a split.
REQ-027 With SPLIT_EN=0, msplit1, msplit2 and split_grant SHALL be constant 0, and RESUME SHALL be unreachable.

Reset
REQ-028 rstn low SHALL immediately force state IDLE and all of the following to 0: bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split pending flag and ssplit history.
REQ-029 rstn low SHALL also reset the last-served pointer to master 2.
REQ-030 Reset asserted mid-transaction or mid-split SHALL discard the pending split with no split_grant pulse afterwards.
REQ-031 The first arbitration after reset release SHALL occur on the first rising edge with rstn high.

Verification
REQ-032 Single request: breq1=1 in IDLE -> bgrant1=1 one cycle later, msel=0; breq1=0 -> bgrant1=0 next cycle, IDLE for >=1 cycle.
REQ-033 Contention: breq1=breq2=1 after reset -> M1 first. Then breq1 drops and re-asserts immediately -> M2 granted after one IDLE cycle, msel=1. Grants are never overlapping.
REQ-034 Split: M1 owns the bus, ssplit 0->1 -> bgrant1=0 and msplit1=1. breq2=1 -> bgrant2 after the turnaround. Once ssplit=0 and breq2 has dropped -> one IDLE cycle, then RESUME with split_grant=1 and bgrant1=1 for 1 cycle, then M1 with msplit1=0.
REQ-035 Resume priority: split pending, ssplit low, breq2=1 in IDLE -> RESUME is chosen, not M2.
REQ-036 Second split ignored: M1 split pending, M2 owns the bus, ssplit pulses again -> M2 keeps its grant and msplit2 stays 0.
REQ-037 Reset mid-split: rstn=0 while msplit1=1 -> all outputs 0 immediately, and after release no split_grant is produced.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant/split signals between masters, slaves and the arbiter
// Ports: none; modport master is the arbiter side, modport slave is the agent side.
interface bus_arbiter_if;
  logic breq1;
  logic breq2;
  logic bgrant1;
  logic bgrant2;
  logic msel;
  logic msplit1;
  logic msplit2;
  logic ssplit;
  logic split_grant;
  modport master (
    input  breq1, breq2, ssplit,
    output bgrant1, bgrant2, msel, msplit1, msplit2, split_grant
  );
  modport slave (
    output breq1, breq2, ssplit,
    input  bgrant1, bgrant2, msel, msplit1, msplit2, split_grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with single outstanding split transaction
// Ports: clk (rising-edge clock), rstn (async active-low reset),
//        bus (bus_arbiter_if.master: breq1/2, ssplit in; bgrant1/2, msel, msplit1/2, split_grant out).
module bus_arbiter #(
  parameter bit SPLIT_EN = 1'b1
) (
  input logic            clk,
  input logic            rstn,
  bus_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, M1, M2, RESUME} state_t;
  state_t state, state_n;
  logic ssplit_q, last, msplit1_n, msplit2_n;
  logic gnt1_n, gnt2_n, msel_n, last_n;
  logic pend, ss_rise, el1, el2;
  // A split is pending exactly while one master is suspended; the suspended one owns the resume.
  assign pend    = bus.msplit1 | bus.msplit2;
  assign ss_rise = SPLIT_EN && bus.ssplit && !ssplit_q;
  assign el1     = bus.breq1 && !bus.msplit1;
  assign el2     = bus.breq2 && !bus.msplit2;
  always_comb begin
    state_n   = state;
    msplit1_n = bus.msplit1;
    msplit2_n = bus.msplit2;
    case (state)
      // last = 1 means master 2 was served last, so master 1 wins a tie.
      IDLE:    state_n = (pend && !bus.ssplit) ? RESUME :
                         (el1 && (!el2 || last)) ? M1 :
                         el2 ? M2 : IDLE;
      M1: begin
        if (ss_rise && !pend) begin
          state_n   = IDLE;
          msplit1_n = 1'b1;
        end else if (!bus.breq1) state_n = IDLE;
      end
      M2: begin
        if (ss_rise && !pend) begin
          state_n   = IDLE;
          msplit2_n = 1'b1;
        end else if (!bus.breq2) state_n = IDLE;
      end
      RESUME: begin
        state_n   = bus.msplit2 ? M2 : M1;
        msplit1_n = 1'b0;
        msplit2_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    gnt1_n = (state_n == M1) || (state_n == RESUME && bus.msplit1);
    gnt2_n = (state_n == M2) || (state_n == RESUME && bus.msplit2);
    msel_n = gnt2_n ? 1'b1 : gnt1_n ? 1'b0 : bus.msel;
    last_n = (state_n == M1) ? 1'b0 : (state_n == M2) ? 1'b1 : last;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      ssplit_q        <= 1'b0;
      last            <= 1'b1;
      bus.bgrant1     <= 1'b0;
      bus.bgrant2     <= 1'b0;
      bus.msel        <= 1'b0;
      bus.msplit1     <= 1'b0;
      bus.msplit2     <= 1'b0;
      bus.split_grant <= 1'b0;
    end else begin
      state           <= state_n;
      ssplit_q        <= bus.ssplit;
      last            <= last_n;
      bus.bgrant1     <= gnt1_n;
      bus.bgrant2     <= gnt2_n;
      bus.msel        <= msel_n;
      bus.msplit1     <= msplit1_n;
      bus.msplit2     <= msplit2_n;
      bus.split_grant <= (state_n == RESUME);
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter, expected output vectors queued per driven cycle
module tb_bus_arbiter;
  logic clk, rstn;
  int checks, errors;
  logic [5:0] exp_q[$];
  bus_arbiter_if bus();
  bus_arbiter #(.SPLIT_EN(1'b1)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // vector = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant}
  function automatic logic [5:0] outs();
    return {bus.bgrant1, bus.bgrant2, bus.msel, bus.msplit1, bus.msplit2, bus.split_grant};
  endfunction
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic b1, input logic b2, input logic ss, input logic [5:0] e);
    bus.breq1  = b1;
    bus.breq2  = b2;
    bus.ssplit = ss;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, outs(), exp_q.pop_front());
    check({tag, "_excl"}, {5'b0, bus.bgrant1 & bus.bgrant2}, 6'b0);
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.breq1  = 1'b0;
    bus.breq2  = 1'b0;
    bus.ssplit = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("reset", outs(), 6'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b1;
    do_reset();
    step("single_req",   1, 0, 0, 6'b100000);
    step("single_hold",  1, 0, 0, 6'b100000);
    step("single_drop",  0, 0, 0, 6'b000000);
    step("single_idle",  0, 0, 0, 6'b000000);
    do_reset();
    step("tie_m1",       1, 1, 0, 6'b100000);
    step("tie_turn",     0, 1, 0, 6'b000000);
    step("tie_m2",       1, 1, 0, 6'b011000);
    step("tie_m2_hold",  1, 1, 0, 6'b011000);
    step("tie_m2_drop",  1, 0, 0, 6'b001000);
    step("tie_m1_again", 1, 0, 0, 6'b100000);
    step("tie_end",      0, 0, 0, 6'b000000);
    do_reset();
    step("sp_m1",        1, 0, 0, 6'b100000);
    step("sp_split",     1, 0, 1, 6'b000100);
    step("sp_m2",        0, 1, 1, 6'b011100);
    step("sp_m2_hold",   0, 1, 1, 6'b011100);
    step("sp_wait_m2",   0, 1, 0, 6'b011100);
    step("sp_m2_drop",   0, 0, 0, 6'b001100);
    step("sp_resume",    0, 1, 0, 6'b100101);
    step("sp_m1_back",   1, 1, 0, 6'b100000);
    step("sp_m1_drop",   0, 1, 0, 6'b000000);
    step("sp_m2_after",  0, 1, 0, 6'b011000);
    step("sp_end",       0, 0, 0, 6'b001000);
    do_reset();
    step("drop_m2",      0, 1, 0, 6'b011000);
    step("drop_split",   0, 0, 1, 6'b001010);
    step("drop_resume",  0, 0, 0, 6'b011011);
    step("drop_m2_back", 0, 1, 0, 6'b011000);
    step("drop_end",     0, 0, 0, 6'b001000);
    do_reset();
    step("two_m1",       1, 0, 0, 6'b100000);
    step("two_split",    1, 0, 1, 6'b000100);
    step("two_m2",       0, 1, 1, 6'b011100);
    step("two_low",      0, 1, 0, 6'b011100);
    step("two_rise",     0, 1, 1, 6'b011100);
    step("two_hold",     0, 1, 1, 6'b011100);
    #3;
    rstn = 1'b0;
    #1;
    check("mid_reset", outs(), 6'b0);
    @(negedge clk);
    bus.breq2  = 1'b0;
    bus.ssplit = 1'b0;
    rstn = 1'b1;
    step("post_rst0",    0, 0, 0, 6'b000000);
    step("post_rst1",    0, 0, 0, 6'b000000);
    step("post_rst2",    0, 0, 0, 6'b000000);
    step("post_req",     1, 0, 0, 6'b100000);
    step("post_end",     0, 0, 0, 6'b000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
